data_mem_arbiter: RTL and testbench

//  Two-requester round-robin arbiter/sequencer in front of the 16 kB data memory.

---
 rtl/data_mem_arbiter_pkg.sv | 21 ++
 rtl/data_mem_arbiter_rr_arb2.sv | 23 ++
 rtl/data_mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared types, defaults and address check for the data memory arbiter
// Purpose: FSM state encoding, default widths/size, and the legality check for a word address.
// Ports: none (package).
package data_mem_arbiter_pkg;

   localparam int DEF_ADDR_W    = 15;
   localparam int DEF_DATA_W    = 16;
   localparam int DEF_MEM_BYTES = 16384;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_t;

   // A word access touches addr and addr+1, so both must lie inside the array
   // and the word must be aligned.
   function automatic logic addr_legal(input logic [31:0] addr, input logic [31:0] mem_bytes);
      return (addr[0] == 1'b0) && (addr <= (mem_bytes - 32'd2));
   endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// rtl/data_mem_arbiter_rr_arb2.sv - two-way round-robin arbiter
// Purpose: pick one of two requesters; on contention the port that did not win last time wins.
// Ports:
//   req_i  [1:0]  request per port
//   last_i        index of the most recent winner
//   gnt_o  [1:0]  one-hot grant (or zero when nobody requests)
module rr_arb2 (
   input  logic [1:0] req_i,
   input  logic       last_i,
   output logic [1:0] gnt_o
);

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin arbiter/sequencer in front of the data memory
// Purpose: shares one rb/wb/adrb/din/dout memory port between port 0 (CPU) and port 1 (loader/DMA).
//   Strobes are launched from posedge, the memory acts on the following negedge, and the
//   read data is captured on the next posedge together with a one-cycle completion pulse.
//   Illegal addresses never reach the memory and complete with an err pulse instead.
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   pN_req_i/we_i/addr_i/wdata_i   request and command for port N (held until granted)
//   pN_gnt_o                       combinational accept (IDLE only)
//   pN_rvalid_o/rdata_o/err_o      registered one-cycle completion for port N
//   mem_rb_o/wb_o/adrb_o/din_o     registered memory strobes, address, write data
//   mem_dout_i                     memory read data
//   busy_o                         high while an access is in flight
module data_mem_arbiter
   import data_mem_arbiter_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MEM_BYTES = DEF_MEM_BYTES
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              p0_req_i,
   input  logic              p0_we_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_wdata_i,
   output logic              p0_gnt_o,
   output logic              p0_rvalid_o,
   output logic [DATA_W-1:0] p0_rdata_o,
   output logic              p0_err_o,
   input  logic              p1_req_i,
   input  logic              p1_we_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_wdata_i,
   output logic              p1_gnt_o,
   output logic              p1_rvalid_o,
   output logic [DATA_W-1:0] p1_rdata_o,
   output logic              p1_err_o,
   output logic              mem_rb_o,
   output logic              mem_wb_o,
   output logic [ADDR_W-1:0] mem_adrb_o,
   output logic [DATA_W-1:0] mem_din_o,
   input  logic [DATA_W-1:0] mem_dout_i,
   output logic              busy_o
);

   state_t            state_q;
   logic              last_q;
   logic              owner_q;
   logic              we_q;
   logic              err_pend_q;
   logic [1:0]        rvalid_q;
   logic [1:0]        err_q;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;

   logic [1:0]        req_d;
   logic [1:0]        gnt_d;
   logic              accept_d;
   logic              sel_d;
   logic              sel_we_d;
   logic [ADDR_W-1:0] sel_addr_d;
   logic [DATA_W-1:0] sel_wdata_d;
   logic              sel_legal_d;

   // Requests are only offered to the arbiter in IDLE, which keeps grants off during ACCESS.
   assign req_d = (state_q == ST_IDLE) ? {p1_req_i, p0_req_i} : 2'b00;

   rr_arb2 u_arb (
      .req_i  (req_d),
      .last_i (last_q),
      .gnt_o  (gnt_d)
   );

   assign p0_gnt_o    = gnt_d[0];
   assign p1_gnt_o    = gnt_d[1];
   assign accept_d    = |gnt_d;
   assign sel_d       = gnt_d[1];
   assign sel_we_d    = sel_d ? p1_we_i    : p0_we_i;
   assign sel_addr_d  = sel_d ? p1_addr_i  : p0_addr_i;
   assign sel_wdata_d = sel_d ? p1_wdata_i : p0_wdata_i;
   assign sel_legal_d = addr_legal(32'(sel_addr_d), 32'(MEM_BYTES));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         last_q     <= 1'b1;   // so the first contested grant goes to port 0
         owner_q    <= 1'b0;
         we_q       <= 1'b0;
         err_pend_q <= 1'b0;
         rvalid_q   <= 2'b00;
         err_q      <= 2'b00;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
         mem_rb_o   <= 1'b0;
         mem_wb_o   <= 1'b0;
         mem_adrb_o <= '0;
         mem_din_o  <= '0;
      end else begin
         // Completion outputs are pulses; they only carry data in their one cycle.
         rvalid_q <= 2'b00;
         err_q    <= 2'b00;
         rdata0_q <= '0;
         rdata1_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (accept_d) begin
                  state_q    <= ST_ACCESS;
                  owner_q    <= sel_d;
                  last_q     <= sel_d;
                  we_q       <= sel_we_d;
                  err_pend_q <= ~sel_legal_d;
                  if (sel_legal_d) begin
                     mem_rb_o   <= ~sel_we_d;
                     mem_wb_o   <= sel_we_d;
                     mem_adrb_o <= sel_addr_d;
                     mem_din_o  <= sel_wdata_d;
                  end
               end
            end
            ST_ACCESS: begin
               // The memory has acted on the negedge inside this cycle; mem_dout_i is settled.
               state_q  <= ST_IDLE;
               mem_rb_o <= 1'b0;
               mem_wb_o <= 1'b0;
               if (err_pend_q) begin
                  err_q[owner_q] <= 1'b1;
               end else begin
                  rvalid_q[owner_q] <= 1'b1;
                  if (owner_q) rdata1_q <= we_q ? '0 : mem_dout_i;
                  else         rdata0_q <= we_q ? '0 : mem_dout_i;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign p0_rvalid_o = rvalid_q[0];
   assign p1_rvalid_o = rvalid_q[1];
   assign p0_err_o    = err_q[0];
   assign p1_err_o    = err_q[1];
   assign p0_rdata_o  = rdata0_q;
   assign p1_rdata_o  = rdata1_q;
   assign busy_o      = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;

   localparam int AW = 15;
   localparam int DW = 16;
   localparam int MB = 16384;

   typedef struct {
      bit          err;
      logic [15:0] data;
      int          due;
   } rsp_t;

   typedef struct {
      bit          we;
      logic [14:0] addr;
      logic [15:0] data;
      int          due;
   } mop_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    req;
   logic [1:0]    we;
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wdata [2];
   wire  [1:0]    gnt;
   wire  [1:0]    rvalid;
   wire  [1:0]    err;
   wire  [DW-1:0] rdata0;
   wire  [DW-1:0] rdata1;
   wire           mem_rb;
   wire           mem_wb;
   wire  [AW-1:0] mem_adrb;
   wire  [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;
   wire           busy;

   logic [7:0] mem     [MB];
   logic [7:0] ref_mem [MB];
   rsp_t       rsp_q [2][$];
   mop_t       mop_q [$];

   int  checks = 0;
   int  errors = 0;
   int  cyc = 0;
   bit  model_on = 1'b0;
   bit  model_busy = 1'b0;
   bit  model_last = 1'b1;
   bit  pending [2];

   data_mem_arbiter dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .p0_req_i    (req[0]),
      .p0_we_i     (we[0]),
      .p0_addr_i   (addr[0]),
      .p0_wdata_i  (wdata[0]),
      .p0_gnt_o    (gnt[0]),
      .p0_rvalid_o (rvalid[0]),
      .p0_rdata_o  (rdata0),
      .p0_err_o    (err[0]),
      .p1_req_i    (req[1]),
      .p1_we_i     (we[1]),
      .p1_addr_i   (addr[1]),
      .p1_wdata_i  (wdata[1]),
      .p1_gnt_o    (gnt[1]),
      .p1_rvalid_o (rvalid[1]),
      .p1_rdata_o  (rdata1),
      .p1_err_o    (err[1]),
      .mem_rb_o    (mem_rb),
      .mem_wb_o    (mem_wb),
      .mem_adrb_o  (mem_adrb),
      .mem_din_o   (mem_din),
      .mem_dout_i  (mem_dout),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [AW-1:0] pick_addr();
      case ($urandom_range(0, 9))
         0:       return 15'h3FFE;
         1:       return 15'h3FFF;
         2:       return 15'($urandom_range(0, 32767)) | 15'd1;
         3:       return 15'h4000 | 15'($urandom_range(0, 16383));
         4:       return 15'h3FF0 + 15'($urandom_range(0, 7) * 2);
         5:       return 15'h0000;
         default: return 15'h0010 + 15'($urandom_range(0, 15) * 2);
      endcase
   endfunction

   task automatic new_cmd(input int k);
      we[k]    = 1'($urandom_range(0, 1));
      addr[k]  = pick_addr();
      wdata[k] = 16'($urandom);
   endtask

   // Reference: what a granted command must produce, derived from the address rule and a byte array.
   task automatic record(input int w);
      int   a;
      rsp_t r;
      mop_t m;
      a     = int'(addr[w]);
      r.due = cyc + 2;
      r.err = !((a % 2 == 0) && (a <= MB - 2));
      r.data = 16'h0000;
      if (!r.err) begin
         m.we   = we[w];
         m.addr = addr[w];
         m.data = wdata[w];
         m.due  = cyc + 1;
         mop_q.push_back(m);
         if (we[w]) begin
            ref_mem[a]     = wdata[w][15:8];
            ref_mem[a + 1] = wdata[w][7:0];
         end else begin
            r.data = {ref_mem[a], ref_mem[a + 1]};
         end
      end
      rsp_q[w].push_back(r);
   endtask

   always @(negedge clk) begin
      // Memory side: every strobe must match the next expected legal access.
      if (mem_rb || mem_wb) begin
         if (mop_q.size() == 0) begin
            chk("mem_unexpected_strobe", {mem_rb, mem_wb, 15'd0, mem_adrb}, 32'd0);
         end else begin
            mop_t m;
            m = mop_q.pop_front();
            chk("mem_rb", {31'd0, mem_rb}, {31'd0, !m.we});
            chk("mem_wb", {31'd0, mem_wb}, {31'd0, m.we});
            chk("mem_adrb", {17'd0, mem_adrb}, {17'd0, m.addr});
            if (m.we) chk("mem_din", {16'd0, mem_din}, {16'd0, m.data});
            chk("mem_cycle", cyc, m.due);
         end
         if (int'(mem_adrb) < MB - 1) begin
            if (mem_wb) begin
               mem[mem_adrb]     = mem_din[15:8];
               mem[mem_adrb + 1] = mem_din[7:0];
            end
            if (mem_rb) mem_dout = {mem[mem_adrb], mem[mem_adrb + 1]};
         end
      end

      // Response side.
      for (int k = 0; k < 2; k++) begin
         if (rvalid[k] || err[k]) begin
            if (rsp_q[k].size() == 0) begin
               chk($sformatf("p%0d_unexpected_rsp", k), {30'd0, rvalid[k], err[k]}, 32'd0);
            end else begin
               rsp_t r;
               r = rsp_q[k].pop_front();
               chk($sformatf("p%0d_rsp_kind", k), {30'd0, rvalid[k], err[k]},
                   r.err ? 32'd1 : 32'd2);
               if (!r.err)
                  chk($sformatf("p%0d_rdata", k), {16'd0, (k == 0) ? rdata0 : rdata1},
                      {16'd0, r.data});
               chk($sformatf("p%0d_rsp_cycle", k), cyc, r.due);
            end
         end
      end

      // Grant side: idle/busy alternation and round-robin on contention.
      if (model_on) begin
         logic [1:0] eg;
         if (model_busy) begin
            chk("busy_access", {31'd0, busy}, 32'd1);
            chk("gnt_in_access", {30'd0, gnt}, 32'd0);
            model_busy = 1'b0;
         end else begin
            chk("busy_idle", {31'd0, busy}, 32'd0);
            if (req == 2'b11)      eg = model_last ? 2'b01 : 2'b10;
            else                   eg = req;
            chk("gnt", {30'd0, gnt}, {30'd0, eg});
            if (eg != 2'b00) begin
               int w;
               w = eg[1] ? 1 : 0;
               record(w);
               model_last = eg[1];
               model_busy = 1'b1;
               pending[w] = 1'b0;
            end
         end
      end
   end

   initial begin
      logic [7:0] keep_hi;
      logic [7:0] keep_lo;
      int         wait_n;

      req = 2'b00;
      we  = 2'b00;
      for (int k = 0; k < 2; k++) begin
         addr[k]    = '0;
         wdata[k]   = '0;
         pending[k] = 1'b0;
      end
      mem_dout = 16'h0000;
      for (int i = 0; i < MB; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_mem_rb", {31'd0, mem_rb}, 32'd0);
      chk("rst_mem_wb", {31'd0, mem_wb}, 32'd0);
      chk("rst_mem_adrb", {17'd0, mem_adrb}, 32'd0);
      chk("rst_mem_din", {16'd0, mem_din}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_rvalid", {30'd0, rvalid}, 32'd0);
      chk("rst_err", {30'd0, err}, 32'd0);
      chk("rst_rdata", {rdata0, rdata1}, 32'd0);
      rst_n = 1'b1;

      // Contested request dropped before the clock edge: grant goes to p0, nothing happens.
      @(posedge clk); #1;
      req = 2'b11; we = 2'b00; addr[0] = 15'h0010; addr[1] = 15'h0010;
      @(negedge clk);
      chk("first_contested_gnt", {30'd0, gnt}, 32'd1);
      #1 req = 2'b00;
      @(negedge clk);
      chk("dropped_req_busy", {31'd0, busy}, 32'd0);

      // Reset in the middle of a write access.
      keep_hi = mem[32];
      keep_lo = mem[33];
      @(posedge clk); #1;
      req = 2'b01; we[0] = 1'b1; addr[0] = 15'h0020; wdata[0] = 16'hAAAA;
      @(negedge clk);
      chk("rst_wr_gnt", {30'd0, gnt}, 32'd1);
      @(posedge clk); #1;
      req = 2'b00;
      chk("rst_wr_started", {30'd0, busy, mem_wb}, 32'd3);
      rst_n = 1'b0;
      #1;
      chk("rst_wr_strobe_drop", {30'd0, mem_wb, mem_rb}, 32'd0);
      chk("rst_wr_busy_drop", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      chk("rst_wr_mem_hi", {24'd0, mem[32]}, {24'd0, keep_hi});
      chk("rst_wr_mem_lo", {24'd0, mem[33]}, {24'd0, keep_lo});
      chk("rst_wr_no_rsp", {28'd0, rvalid, err}, 32'd0);
      rst_n = 1'b1;
      #1;
      model_last = 1'b1;
      model_busy = 1'b0;
      model_on   = 1'b1;

      // Randomized traffic; the first cycle is a contested read to confirm p0 wins after reset.
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < 2; k++) begin
            if (c == 0) begin
               new_cmd(k);
               we[k] = 1'b0;
               pending[k] = 1'b1;
            end else if (!pending[k]) begin
               if ($urandom_range(0, 99) < 60) begin
                  new_cmd(k);
                  pending[k] = 1'b1;
               end
            end else if ($urandom_range(0, 99) < 4) begin
               pending[k] = 1'b0;
            end else if ($urandom_range(0, 99) < 8) begin
               new_cmd(k);
            end
            req[k] = pending[k];
         end
      end

      // Drain outstanding responses with a bounded wait.
      @(posedge clk); #1;
      req = 2'b00;
      pending[0] = 1'b0;
      pending[1] = 1'b0;
      wait_n = 0;
      while ((rsp_q[0].size() + rsp_q[1].size() + mop_q.size()) != 0 && wait_n < 50) begin
         @(negedge clk);
         wait_n++;
      end
      chk("drain_p0", rsp_q[0].size(), 32'd0);
      chk("drain_p1", rsp_q[1].size(), 32'd0);
      chk("drain_mem", mop_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
